// File: rtl/lrwait_queue_ctrl.sv
// LR-wait / SC-wait queue controller: a single reservation slot in front of a memory bank,
// turning waiting LRs into a successor chain that is woken one at a time.
module lrwait_queue_ctrl #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int MetaWidth = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [AddrWidth-1:0]   in_addr_i,
  input  logic [3:0]             in_amo_i,
  input  logic                   in_write_i,
  input  logic [DataWidth-1:0]   in_wdata_i,
  input  logic [DataWidth/8-1:0] in_be_i,
  input  logic [MetaWidth-1:0]   in_meta_i,
  input  logic                   in_lrwait_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DataWidth-1:0]   out_rdata_o,
  output logic [MetaWidth-1:0]   out_meta_o,
  output logic                   out_lrwait_o,
  output logic                   out_error_o,
  output logic                   bank_req_o,
  output logic                   bank_we_o,
  output logic [AddrWidth-1:0]   bank_addr_o,
  output logic [DataWidth-1:0]   bank_wdata_o,
  output logic [DataWidth/8-1:0] bank_be_o,
  input  logic [DataWidth-1:0]   bank_rdata_i
);

  localparam int BeWidth = DataWidth / 8;
  localparam logic [3:0] AmoNone   = 4'h0;
  localparam logic [3:0] AmoLrWait = 4'hC;
  localparam logic [3:0] AmoScWait = 4'hD;

  logic                 r_res_valid;
  logic [AddrWidth-1:0] r_res_addr;
  logic [MetaWidth-1:0] r_res_head;
  logic [MetaWidth-1:0] r_res_tail;
  logic                 r_wait_wakeup;

  logic                 r_out_valid;
  logic [MetaWidth-1:0] r_out_meta;
  logic                 r_out_lrwait;
  logic                 r_out_error;
  logic [DataWidth-1:0] r_out_data;
  logic                 r_from_bank;

  logic                 w_accept;
  logic                 w_addr_hit;
  logic                 w_plain;
  logic                 w_lr;
  logic                 w_sc;
  logic                 w_sc_ok;
  logic                 w_wake_ok;

  logic                 w_resp;
  logic [MetaWidth-1:0] w_resp_meta;
  logic [DataWidth-1:0] w_resp_data;
  logic                 w_resp_lrwait;
  logic                 w_resp_error;
  logic                 w_resp_from_bank;

  logic                 w_res_valid_next;
  logic [AddrWidth-1:0] w_res_addr_next;
  logic [MetaWidth-1:0] w_res_head_next;
  logic [MetaWidth-1:0] w_res_tail_next;
  logic                 w_wait_wakeup_next;

  assign in_ready_o  = !r_out_valid || out_ready_i;
  assign w_accept    = in_valid_i && in_ready_o && !rst_i;
  assign w_addr_hit  = r_res_valid && (in_addr_i == r_res_addr);
  assign w_plain     = !in_lrwait_i && (in_amo_i == AmoNone);
  assign w_lr        = !in_lrwait_i && (in_amo_i == AmoLrWait);
  assign w_sc        = !in_lrwait_i && (in_amo_i == AmoScWait);
  assign w_sc_ok     = w_sc && w_addr_hit && (in_meta_i == r_res_head) && !r_wait_wakeup;
  assign w_wake_ok   = in_lrwait_i && (in_amo_i == AmoLrWait) && w_addr_hit && r_wait_wakeup;

  always_comb begin
    bank_req_o         = 1'b0;
    bank_we_o          = 1'b0;
    bank_addr_o        = '0;
    bank_wdata_o       = '0;
    bank_be_o          = '0;
    w_resp             = 1'b0;
    w_resp_meta        = in_meta_i;
    w_resp_data        = '0;
    w_resp_lrwait      = 1'b0;
    w_resp_error       = 1'b0;
    w_resp_from_bank   = 1'b0;
    w_res_valid_next   = r_res_valid;
    w_res_addr_next    = r_res_addr;
    w_res_head_next    = r_res_head;
    w_res_tail_next    = r_res_tail;
    w_wait_wakeup_next = r_wait_wakeup;

    if (w_accept) begin
      if (in_lrwait_i) begin
        // Non-matching WakeUps vanish silently: no bank access and no response.
        if (w_wake_ok) begin
          w_resp             = 1'b1;
          w_resp_meta        = in_wdata_i[MetaWidth-1:0];
          w_resp_from_bank   = 1'b1;
          w_res_head_next    = in_wdata_i[MetaWidth-1:0];
          w_wait_wakeup_next = 1'b0;
          bank_req_o         = 1'b1;
          bank_addr_o        = r_res_addr;
          bank_be_o          = {BeWidth{1'b1}};
        end
      end else begin
        w_resp = 1'b1;
        if (w_plain) begin
          bank_req_o       = 1'b1;
          bank_we_o        = in_write_i;
          bank_addr_o      = in_addr_i;
          bank_wdata_o     = in_write_i ? in_wdata_i : '0;
          bank_be_o        = in_be_i;
          w_resp_from_bank = !in_write_i;
        end else if (w_lr) begin
          if (!r_res_valid) begin
            w_res_valid_next = 1'b1;
            w_res_addr_next  = in_addr_i;
            w_res_head_next  = in_meta_i;
            w_res_tail_next  = in_meta_i;
            w_resp_from_bank = 1'b1;
            bank_req_o       = 1'b1;
            bank_addr_o      = in_addr_i;
            bank_be_o        = {BeWidth{1'b1}};
          end else if (w_addr_hit) begin
            // Link the newcomer behind the current tail via a SuccUpdate.
            w_resp_meta                 = r_res_tail;
            w_resp_data[MetaWidth-1:0]  = in_meta_i;
            w_resp_lrwait               = 1'b1;
            w_res_tail_next             = in_meta_i;
          end else begin
            w_resp_error = 1'b1;
          end
        end else if (w_sc) begin
          if (w_sc_ok) begin
            bank_req_o   = 1'b1;
            bank_we_o    = 1'b1;
            bank_addr_o  = in_addr_i;
            bank_wdata_o = in_wdata_i;
            bank_be_o    = in_be_i;
            if (r_res_head == r_res_tail) begin
              w_res_valid_next = 1'b0;
            end else begin
              w_wait_wakeup_next = 1'b1;
            end
          end else begin
            w_resp_data = DataWidth'(1);
          end
        end else begin
          w_resp_error = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res_valid   <= 1'b0;
      r_res_addr    <= '0;
      r_res_head    <= '0;
      r_res_tail    <= '0;
      r_wait_wakeup <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_meta    <= '0;
      r_out_lrwait  <= 1'b0;
      r_out_error   <= 1'b0;
      r_out_data    <= '0;
      r_from_bank   <= 1'b0;
    end else begin
      r_res_valid   <= w_res_valid_next;
      r_res_addr    <= w_res_addr_next;
      r_res_head    <= w_res_head_next;
      r_res_tail    <= w_res_tail_next;
      r_wait_wakeup <= w_wait_wakeup_next;
      if (w_resp) begin
        r_out_valid  <= 1'b1;
        r_out_meta   <= w_resp_meta;
        r_out_lrwait <= w_resp_lrwait;
        r_out_error  <= w_resp_error;
        r_out_data   <= w_resp_data;
        r_from_bank  <= w_resp_from_bank;
      end else begin
        if (out_ready_i) begin
          r_out_valid <= 1'b0;
        end
        // Bank data is only valid for one cycle; freeze it in case the consumer stalls.
        if (r_from_bank) begin
          r_out_data  <= bank_rdata_i;
          r_from_bank <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o  = r_out_valid;
  assign out_meta_o   = r_out_meta;
  assign out_lrwait_o = r_out_lrwait;
  assign out_error_o  = r_out_error;
  assign out_rdata_o  = r_from_bank ? bank_rdata_i : r_out_data;

endmodule

// File: tb/tb_lrwait_queue_ctrl.sv
// Self-checking bench for lrwait_queue_ctrl: vector table with a response scoreboard,
// plus hand-written stall and reset-during-stall sequences.
module tb_lrwait_queue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_addr_i = '0;
  logic [3:0]  in_amo_i = '0;
  logic        in_write_i = 1'b0;
  logic [31:0] in_wdata_i = '0;
  logic [3:0]  in_be_i = 4'hF;
  logic [11:0] in_meta_i = '0;
  logic        in_lrwait_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] out_rdata_o;
  logic [11:0] out_meta_o;
  logic        out_lrwait_o;
  logic        out_error_o;
  logic        bank_req_o;
  logic        bank_we_o;
  logic [31:0] bank_addr_o;
  logic [31:0] bank_wdata_o;
  logic [3:0]  bank_be_o;
  logic [31:0] bank_rdata_i = '0;

  lrwait_queue_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_addr_i(in_addr_i),
    .in_amo_i(in_amo_i), .in_write_i(in_write_i), .in_wdata_i(in_wdata_i),
    .in_be_i(in_be_i), .in_meta_i(in_meta_i), .in_lrwait_i(in_lrwait_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_rdata_o(out_rdata_o),
    .out_meta_o(out_meta_o), .out_lrwait_o(out_lrwait_o), .out_error_o(out_error_o),
    .bank_req_o(bank_req_o), .bank_we_o(bank_we_o), .bank_addr_o(bank_addr_o),
    .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o), .bank_rdata_i(bank_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        lrw;
    logic [3:0]  amo;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [11:0] meta;
    logic        eb_req;
    logic        eb_we;
    logic        resp;
    logic [11:0] emeta;
    logic [31:0] erdata;
    logic        elrw;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [11:0] meta;
    logic [31:0] rdata;
    logic        lrw;
    logic        err;
  } resp_t;

  int    checks = 0;
  int    failures = 0;
  resp_t exp_q[$];
  vec_t  vecs[$];
  logic [31:0] mem [0:1023];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic lrw, input logic [3:0] amo, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [11:0] meta, input logic eb_req, input logic eb_we,
                              input logic resp, input logic [11:0] emeta,
                              input logic [31:0] erdata, input logic elrw, input logic eerr);
    vec_t v;
    v.lrw = lrw; v.amo = amo; v.wr = wr; v.addr = addr; v.wdata = wdata; v.meta = meta;
    v.eb_req = eb_req; v.eb_we = eb_we; v.resp = resp; v.emeta = emeta;
    v.erdata = erdata; v.elrw = elrw; v.eerr = eerr;
    return v;
  endfunction

  // Bank model: one-cycle read latency, noise on rdata when no read was issued.
  always @(posedge clk_i) begin
    if (bank_req_o && bank_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (bank_be_o[b]) mem[bank_addr_o[11:2]][b*8 +: 8] <= bank_wdata_o[b*8 +: 8];
      end
    end
    if (bank_req_o && !bank_we_o) bank_rdata_i <= mem[bank_addr_o[11:2]];
    else bank_rdata_i <= $urandom;
  end

  // Scoreboard monitor: compares every completed response handshake.
  always @(negedge clk_i) begin
    #2;
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {20'h0, out_meta_o, out_rdata_o}, 64'h0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_meta", 64'(out_meta_o), 64'(e.meta));
        chk("resp_rdata", 64'(out_rdata_o), 64'(e.rdata));
        chk("resp_flags", 64'({out_lrwait_o, out_error_o}), 64'({e.lrw, e.err}));
      end
    end
  end

  task automatic apply(input vec_t v, input int idx);
    resp_t e;
    @(negedge clk_i);
    in_valid_i  = 1'b1;
    in_lrwait_i = v.lrw;
    in_amo_i    = v.amo;
    in_write_i  = v.wr;
    in_addr_i   = v.addr;
    in_wdata_i  = v.wdata;
    in_meta_i   = v.meta;
    in_be_i     = 4'hF;
    #1;
    $display("vec %0d: lrw=%0b amo=%h addr=%h meta=%h wdata=%h", idx, v.lrw, v.amo, v.addr,
             v.meta, v.wdata);
    chk("in_ready", 64'(in_ready_o), 64'd1);
    chk("bank_req_we", 64'({bank_req_o, bank_we_o}), 64'({v.eb_req, v.eb_we}));
    chk("bank_addr", 64'(bank_addr_o), v.eb_req ? 64'(v.addr) : 64'd0);
    chk("bank_wdata", 64'(bank_wdata_o), v.eb_we ? 64'(v.wdata) : 64'd0);
    if (v.resp) begin
      e.meta = v.emeta; e.rdata = v.erdata; e.lrw = v.elrw; e.err = v.eerr;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h0000CAFE;
    mem[32'h200 >> 2] = 32'h0000BEEF;

    //        lrw amo   wr addr      wdata       meta    breq bwe resp emeta   erdata      elrw err
    vecs.push_back(mk(0, 4'hC, 0, 32'h100, 32'h0,     12'h011, 1, 0, 1, 12'h011, 32'hCAFE, 0, 0));
    vecs.push_back(mk(0, 4'hC, 0, 32'h100, 32'h0,     12'h022, 0, 0, 1, 12'h011, 32'h022,  1, 0));
    vecs.push_back(mk(0, 4'hC, 0, 32'h100, 32'h0,     12'h033, 0, 0, 1, 12'h022, 32'h033,  1, 0));
    vecs.push_back(mk(0, 4'hD, 0, 32'h100, 32'h5,     12'h033, 0, 0, 1, 12'h033, 32'h1,    0, 0));
    vecs.push_back(mk(0, 4'hD, 0, 32'h104, 32'h5,     12'h011, 0, 0, 1, 12'h011, 32'h1,    0, 0));
    vecs.push_back(mk(0, 4'hC, 0, 32'h200, 32'h0,     12'h044, 0, 0, 1, 12'h044, 32'h0,    0, 1));
    vecs.push_back(mk(0, 4'hD, 0, 32'h100, 32'h5,     12'h011, 1, 1, 1, 12'h011, 32'h0,    0, 0));
    vecs.push_back(mk(0, 4'hD, 0, 32'h100, 32'h6,     12'h011, 0, 0, 1, 12'h011, 32'h1,    0, 0));
    vecs.push_back(mk(1, 4'hC, 0, 32'h104, 32'h022,   12'h011, 0, 0, 0, 12'h000, 32'h0,    0, 0));
    vecs.push_back(mk(1, 4'hC, 0, 32'h100, 32'h022,   12'h011, 1, 0, 1, 12'h022, 32'h5,    0, 0));
    vecs.push_back(mk(0, 4'h0, 1, 32'h300, 32'hABCD,  12'h0AA, 1, 1, 1, 12'h0AA, 32'h0,    0, 0));
    vecs.push_back(mk(0, 4'h0, 0, 32'h300, 32'h0,     12'h0AB, 1, 0, 1, 12'h0AB, 32'hABCD, 0, 0));
    vecs.push_back(mk(0, 4'hD, 0, 32'h100, 32'h7,     12'h022, 1, 1, 1, 12'h022, 32'h0,    0, 0));
    vecs.push_back(mk(1, 4'hC, 0, 32'h100, 32'h033,   12'h000, 1, 0, 1, 12'h033, 32'h7,    0, 0));
    vecs.push_back(mk(0, 4'hD, 0, 32'h100, 32'h9,     12'h033, 1, 1, 1, 12'h033, 32'h0,    0, 0));
    vecs.push_back(mk(0, 4'hC, 0, 32'h200, 32'h0,     12'h055, 1, 0, 1, 12'h055, 32'hBEEF, 0, 0));

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid_o), 64'd0);
    chk("reset_in_ready", 64'(in_ready_o), 64'd1);
    chk("reset_bank_req", 64'(bank_req_o), 64'd0);

    foreach (vecs[i]) apply(vecs[i], i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_lrwait_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Stall: plain read with consumer not ready; data must survive bank noise.
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_amo_i = 4'h0; in_write_i = 1'b0; in_addr_i = 32'h300;
    in_wdata_i = '0; in_meta_i = 12'h0BB;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      $display("stall cycle %0d: valid=%0b rdata=%h in_ready=%0b", c, out_valid_o, out_rdata_o,
               in_ready_o);
      chk("stall_valid", 64'(out_valid_o), 64'd1);
      chk("stall_rdata", 64'(out_rdata_o), 64'h0000ABCD);
      chk("stall_in_ready", 64'(in_ready_o), 64'd0);
      @(negedge clk_i);
    end

    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    $display("after mid-stall reset: valid=%0b in_ready=%0b", out_valid_o, in_ready_o);
    chk("rst_stall_valid", 64'(out_valid_o), 64'd0);
    chk("rst_stall_in_ready", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b1;

    apply(mk(0, 4'hC, 0, 32'h100, 32'h0, 12'h077, 1, 0, 1, 12'h077, 32'h9,   0, 0), 100);
    apply(mk(0, 4'hC, 0, 32'h100, 32'h0, 12'h088, 0, 0, 1, 12'h077, 32'h088, 1, 0), 101);
    @(negedge clk_i);
    in_valid_i = 1'b0;

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk_i);
    @(negedge clk_i);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
